counter_seq_ctrl: RTL and testbench

Sequencer for the team's up-counter datapath (clk/rst/ebl, bus_width-wide out).
- Accepts a start request carrying a terminal value and a run count.
- Drives the counter's clear and enable so that it counts 0..limit, `runs` times back to back, with pause support.
- Signals completion with a one-cycle done pulse.
- Sits between a host/control FSM and a counter_core instance; the count output mirrors the datapath.

---
 rtl/counter_seq_ctrl_pkg.sv | 19 +
 rtl/counter_seq_ctrl_core.sv | 19 +
 rtl/counter_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and defaults for the counter sequencer slice.
// Optional abort input is controlled by COUNTER_SEQ_CTRL_ABORT_EN.
package counter_seq_pkg;

    localparam int unsigned BUS_WIDTH_DEF = 8;
    localparam int unsigned RUN_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_busy(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_core.sv
// Up-counter datapath: synchronous clear, increment while enabled.
module counter_core #(
    parameter int unsigned bus_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ebl,
    output logic [bus_width-1:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (ebl) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer driving counter_core through 0..limit, `runs` times, with pause.
// Define COUNTER_SEQ_CTRL_ABORT_EN to add the `abort` input.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int unsigned bus_width = BUS_WIDTH_DEF,
    parameter int unsigned run_width = RUN_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
`ifdef COUNTER_SEQ_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [bus_width-1:0] limit,
    input  logic [run_width-1:0] runs,
    output logic                 busy,
    output logic                 done,
    output logic                 cnt_rst,
    output logic                 cnt_ebl,
    output logic [bus_width-1:0] count,
    output logic [run_width-1:0] run_idx
);

    state_t                 state, state_d;
    logic [bus_width-1:0]   limit_q, limit_d;
    logic [run_width-1:0]   runs_q, runs_d;
    logic [run_width-1:0]   run_idx_q, run_idx_d;
    logic                   terminal;
    logic                   last_run;
    logic                   abort_hit;
    logic                   core_rst;

`ifdef COUNTER_SEQ_CTRL_ABORT_EN
    assign abort_hit = abort && (state == ST_CLEAR || state == ST_RUN);
`else
    assign abort_hit = 1'b0;
`endif

    assign terminal = (count == limit_q);
    assign last_run = (run_idx_q == runs_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            limit_q   <= '0;
            runs_q    <= '0;
            run_idx_q <= '0;
        end else begin
            state     <= state_d;
            limit_q   <= limit_d;
            runs_q    <= runs_d;
            run_idx_q <= run_idx_d;
        end
    end

    always_comb begin
        state_d   = state;
        limit_d   = limit_q;
        runs_d    = runs_q;
        run_idx_d = run_idx_q;
        cnt_rst   = 1'b0;
        cnt_ebl   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    limit_d   = limit;
                    runs_d    = runs;
                    run_idx_d = '0;
                    state_d   = (runs == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_rst = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Terminal count ends the run even while paused.
                if (terminal) begin
                    if (last_run) begin
                        state_d = ST_DONE;
                    end else begin
                        run_idx_d = run_idx_q + 1'b1;
                        state_d   = ST_CLEAR;
                    end
                end else if (!pause) begin
                    cnt_ebl = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort clears the datapath on the way back to IDLE, with no done pulse.
        if (abort_hit) begin
            state_d   = ST_IDLE;
            run_idx_d = run_idx_q;
            cnt_rst   = 1'b1;
            cnt_ebl   = 1'b0;
        end
    end

    assign busy     = is_busy(state);
    assign done     = (state == ST_DONE);
    assign run_idx  = run_idx_q;
    assign core_rst = rst | cnt_rst;

    counter_core #(
        .bus_width (bus_width)
    ) u_core (
        .clk (clk),
        .rst (core_rst),
        .ebl (cnt_ebl),
        .out (count)
    );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl; abort test enabled with COUNTER_SEQ_CTRL_ABORT_EN.
module tb_counter_seq_ctrl;

    localparam int BW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, start, pause;
    logic [BW-1:0] limit, count;
    logic [RW-1:0] runs, run_idx;
    logic          busy, done, cnt_rst, cnt_ebl;
`ifdef COUNTER_SEQ_CTRL_ABORT_EN
    logic          abort;
`endif

    always #5 clk = ~clk;

    counter_seq_ctrl #(
        .bus_width (BW),
        .run_width (RW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
`ifdef COUNTER_SEQ_CTRL_ABORT_EN
        .abort   (abort),
`endif
        .limit   (limit),
        .runs    (runs),
        .busy    (busy),
        .done    (done),
        .cnt_rst (cnt_rst),
        .cnt_ebl (cnt_ebl),
        .count   (count),
        .run_idx (run_idx)
    );

    typedef struct packed {
        logic          pause;
        logic          busy;
        logic          done;
        logic          cnt_rst;
        logic          cnt_ebl;
        logic [BW-1:0] count;
        logic [RW-1:0] run_idx;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] last_count;

    function automatic exp_t mk(input logic p, input logic b, input logic d, input logic r,
                                input logic e, input int c, input int idx);
        exp_t x;
        x.pause   = p;
        x.busy    = b;
        x.done    = d;
        x.cnt_rst = r;
        x.cnt_ebl = e;
        x.count   = BW'(c);
        x.run_idx = RW'(idx);
        return x;
    endfunction

    // Expected per-cycle trace from the first busy cycle through DONE.
    task automatic build_trace(input int lim, input int rns, input int pause_at, input int pause_len);
        int prev;
        prev = int'(last_count);
        for (int r = 0; r < rns; r++) begin
            sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, prev, r));
            for (int c = 0; c <= lim; c++) begin
                if (r == 0 && c == pause_at) begin
                    for (int k = 0; k < pause_len; k++)
                        sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c, r));
                end
                sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, c != lim, c, r));
            end
            prev = lim;
        end
        sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, prev, (rns == 0) ? 0 : rns - 1));
        last_count = BW'(prev);
    endtask

    task automatic run_seq(input string name, input int lim, input int rns,
                           input int pause_at, input int pause_len, input logic noise);
        int   busy_seen;
        int   exp_busy;
        int   cyc;
        exp_t e;
        busy_seen = 0;
        cyc       = 0;
        exp_busy  = rns * (lim + 2) + 1 + ((pause_at >= 0) ? pause_len : 0);
        build_trace(lim, rns, pause_at, pause_len);
        @(negedge clk);
        start = 1'b1;
        pause = 1'b0;
        limit = BW'(lim);
        runs  = RW'(rns);
        while (sb.size() > 0) begin
            @(negedge clk);
            e     = sb.pop_front();
            start = noise;
            pause = e.pause;
            if (noise) begin
                limit = BW'($urandom);
                runs  = RW'($urandom);
            end
            #1;
            cyc++;
            checks++;
            if ({busy, done, cnt_rst, cnt_ebl, count, run_idx} !==
                {e.busy, e.done, e.cnt_rst, e.cnt_ebl, e.count, e.run_idx}) begin
                errors++;
                $display("FAIL %s cyc%0d: got busy=%0b done=%0b cnt_rst=%0b cnt_ebl=%0b count=%0d run_idx=%0d; expected busy=%0b done=%0b cnt_rst=%0b cnt_ebl=%0b count=%0d run_idx=%0d",
                         name, cyc, busy, done, cnt_rst, cnt_ebl, count, run_idx,
                         e.busy, e.done, e.cnt_rst, e.cnt_ebl, e.count, e.run_idx);
            end
            if (busy === 1'b1) busy_seen++;
        end
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== last_count) begin
            errors++;
            $display("FAIL %s idle: got busy=%0b done=%0b count=%0d; expected busy=0 done=0 count=%0d",
                     name, busy, done, count, last_count);
        end
        checks++;
        if (busy_seen != exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_seen, exp_busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        limit = '0;
        runs  = '0;
`ifdef COUNTER_SEQ_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, cnt_rst, cnt_ebl, count, run_idx} !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%0b done=%0b cnt_rst=%0b cnt_ebl=%0b count=%0d run_idx=%0d; expected all 0",
                     busy, done, cnt_rst, cnt_ebl, count, run_idx);
        end
        rst        = 1'b0;
        last_count = '0;
    endtask

    task automatic wait_count(input string name, input int target);
        int n;
        n = 0;
        while (!(busy === 1'b1 && count === BW'(target)) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s wait: count=%0d never reached %0d (timeout)", name, count, target);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        @(negedge clk);
        start = 1'b1;
        limit = BW'(10);
        runs  = RW'(2);
        @(negedge clk);
        start = 1'b0;
        wait_count("reset_mid_run", 5);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, done, cnt_rst, cnt_ebl, count, run_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%0b done=%0b cnt_rst=%0b cnt_ebl=%0b count=%0d run_idx=%0d; expected all 0",
                     busy, done, cnt_rst, cnt_ebl, count, run_idx);
        end
        rst       = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_run_quiet: got %0d busy/done cycles, expected 0", done_seen);
        end
        last_count = '0;
    endtask

`ifdef COUNTER_SEQ_CTRL_ABORT_EN
    task automatic test_abort();
        int done_seen;
        @(negedge clk);
        start = 1'b1;
        limit = BW'(9);
        runs  = RW'(1);
        @(negedge clk);
        start = 1'b0;
        wait_count("abort", 6);
        abort = 1'b1;
        #1;
        checks++;
        if (cnt_rst !== 1'b1 || cnt_ebl !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle: got cnt_rst=%0b cnt_ebl=%0b busy=%0b; expected 1 0 1", cnt_rst, cnt_ebl, busy);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cnt_rst !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b done=%0b cnt_rst=%0b count=%0d; expected 0 0 0 0",
                     busy, done, cnt_rst, count);
        end
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles, expected 0", done_seen);
        end
        last_count = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_run();
        run_seq("runs0", 5, 0, -1, 0, 1'b0);
        run_seq("lim3_runs2", 3, 2, -1, 0, 1'b0);
        run_seq("lim0_runs3", 0, 3, -1, 0, 1'b0);
        run_seq("pause_busy_start", 4, 1, 2, 3, 1'b1);
`ifdef COUNTER_SEQ_CTRL_ABORT_EN
        test_abort();
`endif
        run_seq("lim_max", 255, 1, -1, 0, 1'b0);
        run_seq("back_to_back", 2, 3, 1, 2, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
